mul_hilo_ctrl: RTL and testbench
================================

Name: mul_hilo_ctrl

Overview:
Sequencing and writeback stage placed directly around the radix-4 Booth multiplier. It accepts a multiply request from the control unit and latches the operands. It holds the operands stable toward the multiplier, issues clear and step strobes for 16 radix-4 iterations, then captures the 64-bit signed product into the architectural HI/LO registers. It also services direct HI/LO writes (mthi/mtlo) and exposes HI/LO for reads (mfhi/mflo).

Parameters:
WIDTH, 32, operand and HI/LO register width
ITERS, 16, radix-4 step count (WIDTH/2); must be even-width derived, not overridden independently

Ports:
clk  in  1  system clock, all state changes on rising edge
clear  in  1  synchronous, active-high reset
start  in  1  multiply request; accepted only when ready=1
op_a  in  WIDTH  multiplicand (signed)
op_b  in  WIDTH  multiplier (signed)
ready  out  1  high in IDLE only
busy  out  1  high in CLR, STEP, CAPTURE
done  out  1  one-cycle pulse; HI/LO already hold the new product
mul_a  out  WIDTH  latched op_a driven to multiplier
mul_b  out  WIDTH  latched op_b driven to multiplier
mul_clr  out  1  zero multiplier accumulator and index
mul_step  out  1  advance multiplier by one radix-4 step
prod_hi  in  WIDTH  multiplier product bits [63:32]
prod_lo  in  WIDTH  multiplier product bits [31:0]
hi_wr  in  1  direct write of wdata into HI
lo_wr  in  1  direct write of wdata into LO
wdata  in  WIDTH  direct write data
hi_out  out  WIDTH  HI register
lo_out  out  WIDTH  LO register

Behaviour:
- Clock and reset: single clock clk; reset is clear, synchronous, active-high.
- Reset values (clear=1 at an edge): state=IDLE, step counter=0, mul_a=mul_b=0, hi_out=lo_out=0, ready=1, busy=0, done=0, mul_clr=0, mul_step=0. Clear wins over every other input in the same cycle.
- States: IDLE, CLR, STEP, CAPTURE, DONE.
- IDLE: ready=1. If start=1 at edge T, latch op_a/op_b into mul_a/mul_b and go to CLR.
- CLR (cycle T+1): mul_clr=1, counter<=0. Go to STEP.
- STEP (cycles T+2..T+17): mul_step=1 every cycle, counter increments. Leave to CAPTURE when counter==ITERS-1 at the edge. The result is exactly ITERS step pulses.
- CAPTURE (T+18): hi_out<=prod_hi, lo_out<=prod_lo at the closing edge. Go to DONE.
- DONE (T+19): done=1, busy=0, ready=0. Go to IDLE. Next start is accepted at edge T+20.
- mul_a/mul_b hold their values from the latch edge until the next accepted start. They are not cleared on DONE.
- start outside IDLE is ignored: no queuing, no error flag.
- Direct writes are honoured in any state. hi_wr/lo_wr update the register at the edge.
- A direct write in the CAPTURE cycle loses to the capture.
- hi_wr and lo_wr together write wdata to both registers.
- clear mid-operation aborts immediately: IDLE next cycle, HI/LO zeroed, no done pulse. The multiplier is re-cleared by the next CLR.
- Product is the two's-complement signed 64-bit result. The block performs no arithmetic; width checks and sign handling live in the multiplier.
- Outputs mul_clr, mul_step, ready, busy and done are decoded from registered state only, with no combinational path from inputs.

Decomposition:
- Shared package mul_pkg holds:
  - WIDTH and ITERS constants
  - state enum (IDLE, CLR, STEP, CAPTURE, DONE)
  - the latency constant MUL_LAT=19, cycles from the accepting edge to the done cycle, for the control unit's stall logic
- One sub-module, hilo_regs: HI/LO register pair with clear, capture port and direct-write port, capture priority inside.
- The FSM and counter stay in mul_hilo_ctrl.

Test Plan:
All scenarios use a bench multiplier model: accumulator zeroed on mul_clr, signed product presented after ITERS mul_step pulses.
1. op_a=7, op_b=6, start at edge T -> mul_clr at T+1, 16 mul_step cycles, done at T+19; hi_out=0x00000000, lo_out=0x0000002A.
2. op_a=-3, op_b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1; op_a=0x80000000, op_b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
3. start re-asserted with op_a=9 at T+5 -> ignored, mul_a stays at first operand, exactly one done. Back-to-back start at T+20 is accepted.
4. clear at T+8 -> IDLE and ready=1 at T+9, hi_out=lo_out=0, no done pulse. New start at T+9 completes normally.
5. hi_wr=1, wdata=0x12345678 in IDLE -> hi_out=0x12345678 next cycle, lo_out unchanged. hi_wr during the CAPTURE cycle -> hi_out equals prod_hi.
6. Count mul_step pulses across 3 consecutive multiplies -> exactly 16 each. mul_clr exactly 1 each. busy high for exactly 18 cycles per operation.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the multiply sequencer around the radix-4 Booth multiplier.
package mul_pkg;

    localparam int WIDTH   = 32;
    localparam int ITERS   = WIDTH / 2;
    localparam int CNT_W   = $clog2(ITERS);
    // Accepting edge to done cycle: CLR + ITERS steps + CAPTURE + DONE.
    localparam int MUL_LAT = ITERS + 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STEP,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair; product capture beats direct mthi/mtlo writes.
module hilo_regs
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             cap_en,
    input  logic [WIDTH-1:0] cap_hi,
    input  logic [WIDTH-1:0] cap_lo,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (clear) begin
            hi <= '0;
            lo <= '0;
        end else if (cap_en) begin
            hi <= cap_hi;
            lo <= cap_lo;
        end else begin
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
        end
    end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multiply sequencer: latches operands, strobes the Booth multiplier through ITERS steps, writes HI/LO.
module mul_hilo_ctrl
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_clr,
    output logic             mul_step,
    input  logic [WIDTH-1:0] prod_hi,
    input  logic [WIDTH-1:0] prod_lo,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             capture;

    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clear)              cnt <= '0;
        else if (state == CLR)  cnt <= '0;
        else if (state == STEP) cnt <= cnt + 1'b1;
    end

    // Operands stay on the multiplier inputs until the next accepted start.
    always_ff @(posedge clk) begin
        if (clear) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (state == IDLE && start) begin
            mul_a <= op_a;
            mul_b <= op_b;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mul_clr   = 1'b0;
        mul_step  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = CLR;
            end
            CLR: begin
                busy      = 1'b1;
                mul_clr   = 1'b1;
                state_nxt = STEP;
            end
            STEP: begin
                busy     = 1'b1;
                mul_step = 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    hilo_regs u_hilo (
        .clk    (clk),
        .clear  (clear),
        .cap_en (capture),
        .cap_hi (prod_hi),
        .cap_lo (prod_lo),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .wdata  (wdata),
        .hi     (hi_out),
        .lo     (lo_out)
    );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural step-counting multiplier model.
module tb_mul_hilo_ctrl;
    import mul_pkg::*;

    logic             clk = 1'b0;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic             ready, busy, done;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_clr, mul_step;
    logic [WIDTH-1:0] prod_hi, prod_lo;
    logic             hi_wr, lo_wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi_out, lo_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step = 0, n_clr = 0, n_busy = 0, n_done = 0;

    always #5 clk = ~clk;

    mul_hilo_ctrl dut (
        .clk(clk), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy), .done(done), .mul_a(mul_a), .mul_b(mul_b),
        .mul_clr(mul_clr), .mul_step(mul_step), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out)
    );

    // Multiplier model: product appears only after the ITERS-th step pulse.
    logic [63:0] prod_model;
    int          model_steps;
    always @(posedge clk) begin
        if (mul_clr) begin
            prod_model  <= '0;
            model_steps <= 0;
        end else if (mul_step) begin
            model_steps <= model_steps + 1;
            if (model_steps == ITERS - 1)
                prod_model <= 64'($signed(mul_a)) * 64'($signed(mul_b));
        end
    end
    assign prod_hi = prod_model[63:32];
    assign prod_lo = prod_model[31:0];

    always @(negedge clk) begin
        if (mul_step) n_step++;
        if (mul_clr)  n_clr++;
        if (busy)     n_busy++;
        if (done)     n_done++;
    end

    task automatic zero_monitors();
        @(posedge clk);
        n_step = 0; n_clr = 0; n_busy = 0; n_done = 0;
        @(negedge clk);
    endtask

    // Drives start at the current negedge, returns on the done cycle (or after a bound).
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int lat, output logic clr1);
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        clr1 = mul_clr;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hFFFF_FFFF;
        op_a = 32'h1; op_b = 32'h1;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready got %b exp 1", ready); else n_pass++;
        n_checks++; if ({busy, done, mul_clr, mul_step} !== 4'b0000) $display("[TB] FAIL reset_strobes got %b exp 0000", {busy, done, mul_clr, mul_step}); else n_pass++;
        n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) $display("[TB] FAIL reset_hilo got %h_%h exp 0_0", hi_out, lo_out); else n_pass++;
        n_checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) $display("[TB] FAIL reset_operands got %h/%h exp 0/0", mul_a, mul_b); else n_pass++;
        clear = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic clr1;
        zero_monitors();
        do_mul(32'd7, 32'd6, lat, clr1);
        n_checks++; if (clr1 !== 1'b1) $display("[TB] FAIL basic_clr_t1 got %b exp 1", clr1); else n_pass++;
        n_checks++; if (lat !== MUL_LAT) $display("[TB] FAIL basic_latency got %0d exp %0d", lat, MUL_LAT); else n_pass++;
        n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h2A) $display("[TB] FAIL basic_product got %h_%h exp 00000000_0000002a", hi_out, lo_out); else n_pass++;
        n_checks++; if (ready !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL basic_done_flags got ready=%b busy=%b exp 0 0", ready, busy); else n_pass++;
        @(posedge clk);
        n_checks++; if (n_step !== 16) $display("[TB] FAIL basic_steps got %0d exp 16", n_step); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL basic_after_done got done=%b ready=%b exp 0 1", done, ready); else n_pass++;
    endtask

    task automatic test_signed();
        int lat; logic clr1;
        do_mul(32'hFFFF_FFFD, 32'd5, lat, clr1);
        n_checks++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF1) $display("[TB] FAIL signed_neg got %h_%h exp ffffffff_fffffff1", hi_out, lo_out); else n_pass++;
        @(negedge clk);
        do_mul(32'h8000_0000, 32'h8000_0000, lat, clr1);
        n_checks++; if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) $display("[TB] FAIL signed_minmin got %h_%h exp 40000000_00000000", hi_out, lo_out); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat; logic clr1;
        zero_monitors();
        start = 1'b1; op_a = 32'd11; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op_a = 32'd9;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (mul_a !== 32'd11) $display("[TB] FAIL ignore_mul_a got %h exp 0000000b", mul_a); else n_pass++;
        lat = 6;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lat !== MUL_LAT) $display("[TB] FAIL ignore_latency got %0d exp %0d", lat, MUL_LAT); else n_pass++;
        n_checks++; if (lo_out !== 32'h21 || mul_a !== 32'd11) $display("[TB] FAIL ignore_result got lo=%h mul_a=%h exp 00000021 0000000b", lo_out, mul_a); else n_pass++;
        @(posedge clk);
        n_checks++; if (n_done !== 1) $display("[TB] FAIL ignore_done_count got %0d exp 1", n_done); else n_pass++;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("[TB] FAIL b2b_ready got %b exp 1", ready); else n_pass++;
        do_mul(32'h0001_0000, 32'h0001_0000, lat, clr1);
        n_checks++; if (lat !== MUL_LAT || hi_out !== 32'h1 || lo_out !== 32'h0) $display("[TB] FAIL b2b_result got lat=%0d %h_%h exp 19 00000001_00000000", lat, hi_out, lo_out); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat; logic clr1;
        zero_monitors();
        start = 1'b1; op_a = 32'd100; op_b = 32'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL abort_idle got ready=%b busy=%b exp 1 0", ready, busy); else n_pass++;
        n_checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) $display("[TB] FAIL abort_hilo got %h_%h exp 0_0", hi_out, lo_out); else n_pass++;
        n_checks++; if (n_done !== 0) $display("[TB] FAIL abort_no_done got %0d exp 0", n_done); else n_pass++;
        do_mul(32'd5, 32'hFFFF_FFFC, lat, clr1);
        n_checks++; if (lat !== MUL_LAT || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEC) $display("[TB] FAIL abort_restart got lat=%0d %h_%h exp 19 ffffffff_ffffffec", lat, hi_out, lo_out); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_direct_write();
        hi_wr = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_wr = 1'b0;
        n_checks++; if (hi_out !== 32'h1234_5678 || lo_out !== 32'hFFFF_FFEC) $display("[TB] FAIL mthi got %h_%h exp 12345678_ffffffec", hi_out, lo_out); else n_pass++;
        lo_wr = 1'b1; wdata = 32'hCAFE_BABE;
        @(negedge clk);
        lo_wr = 1'b0;
        n_checks++; if (hi_out !== 32'h1234_5678 || lo_out !== 32'hCAFE_BABE) $display("[TB] FAIL mtlo got %h_%h exp 12345678_cafebabe", hi_out, lo_out); else n_pass++;
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        n_checks++; if (hi_out !== 32'h0F0F_0F0F || lo_out !== 32'h0F0F_0F0F) $display("[TB] FAIL both_wr got %h_%h exp 0f0f0f0f_0f0f0f0f", hi_out, lo_out); else n_pass++;
        start = 1'b1; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        hi_wr = 1'b1; wdata = 32'h55AA_55AA;
        @(negedge clk);
        hi_wr = 1'b0;
        n_checks++; if (hi_out !== 32'h55AA_55AA) $display("[TB] FAIL wr_in_step got %h exp 55aa55aa", hi_out); else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || mul_step !== 1'b0) $display("[TB] FAIL capture_cycle got busy=%b step=%b exp 1 0", busy, mul_step); else n_pass++;
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        n_checks++; if (done !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'hC) $display("[TB] FAIL capture_wins got done=%b %h_%h exp 1 00000000_0000000c", done, hi_out, lo_out); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[3], vb[3], eh[3], el[3];
        int lat; logic clr1;
        va = '{32'd1000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        vb = '{32'hFFFF_FC18, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        eh = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h0};
        el = '{32'hFFF0_BDC0, 32'h0000_0001, 32'h1};
        for (int i = 0; i < 3; i++) begin
            zero_monitors();
            do_mul(va[i], vb[i], lat, clr1);
            n_checks++; if (lat !== MUL_LAT || hi_out !== eh[i] || lo_out !== el[i]) $display("[TB] FAIL b2b%0d_product got lat=%0d %h_%h exp 19 %h_%h", i, lat, hi_out, lo_out, eh[i], el[i]); else n_pass++;
            @(posedge clk);
            n_checks++; if (n_step !== 16 || n_clr !== 1) $display("[TB] FAIL b2b%0d_strobes got step=%0d clr=%0d exp 16 1", i, n_step, n_clr); else n_pass++;
            n_checks++; if (n_busy !== 18 || n_done !== 1) $display("[TB] FAIL b2b%0d_busy got busy=%0d done=%0d exp 18 1", i, n_busy, n_done); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; start = 1'b1; hi_wr = 1'b1; wdata = 32'hAAAA_AAAA; op_a = 32'd2;
        @(negedge clk);
        clear = 1'b0; start = 1'b0; hi_wr = 1'b0;
        n_checks++; if (ready !== 1'b1 || hi_out !== 32'h0 || mul_a !== 32'h0) $display("[TB] FAIL clear_priority got ready=%b hi=%h mul_a=%h exp 1 0 0", ready, hi_out, mul_a); else n_pass++;
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_signed();
        test_ignore_start();
        test_abort();
        test_direct_write();
        test_back_to_back();
        test_clear_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
